data_mem_responder: RTL

- Memory-side responder for the pipeline's M-stage load/store interface.
- Accepts the M-stage address, store data, Func3 and read/write strobes.
- Performs byte/halfword/word stores with lane masking, and loads with alignment plus sign/zero extension.
- Inserts a configurable number of wait states, signalled to the hazard unit as an M-stage stall.

---
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/data_mem_responder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// M-stage load/store bus between the pipeline and the data memory responder.
// The pipeline holds every request field stable while MemStallM is high.
interface data_mem_responder_if;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  Func3M;
    logic [31:0] ReadDataM;
    logic        MemStallM;
    logic        MemErrM;

    modport master (
        output MemReadM, MemWriteM, ALUResultM, WriteDataM, Func3M,
        input  ReadDataM, MemStallM, MemErrM
    );

    modport slave (
        input  MemReadM, MemWriteM, ALUResultM, WriteDataM, Func3M,
        output ReadDataM, MemStallM, MemErrM
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder for the M stage: lane-masked stores, aligned and
// sign/zero-extended loads, and LATENCY wait states reported as MemStallM.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam bit          ZERO_LAT = (LATENCY == 0);
    localparam bit          ONE_LAT  = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] cap;
    logic [31:0] mem [DEPTH];

    logic          req_c;
    logic          store_c;
    logic          load_c;
    logic          illegal_c;
    logic          misalign_c;
    logic          err_c;
    logic          resp_c;
    logic          we_c;
    logic [AW-1:0] idx_c;
    logic [1:0]    off_c;
    logic [3:0]    be_c;
    logic [31:0]   wlane_c;
    logic [31:0]   word_c;
    logic [7:0]    byte_c;
    logic [15:0]   half_c;
    logic [31:0]   load_data_c;
    logic          unused_addr_c;

    // Upper address bits wrap the word index modulo DEPTH.
    assign idx_c         = bus.ALUResultM[AW+1:2];
    assign off_c         = bus.ALUResultM[1:0];
    assign unused_addr_c = ^bus.ALUResultM[31:AW+2];

    // Request decode; a simultaneous read and write is treated as a store.
    always_comb begin
        req_c      = bus.MemReadM | bus.MemWriteM;
        store_c    = bus.MemWriteM;
        load_c     = bus.MemReadM & ~bus.MemWriteM;
        illegal_c  = (bus.Func3M[1:0] == 2'b11)
                   | (bus.Func3M[2] & bus.Func3M[1])
                   | (store_c & bus.Func3M[2]);
        misalign_c = ((bus.Func3M[1:0] == 2'b01) & off_c[0])
                   | ((bus.Func3M[1:0] == 2'b10) & (off_c != 2'b00));
        err_c      = illegal_c | misalign_c;
    end

    // Store lane enables and replicated write data.
    always_comb begin
        be_c    = 4'b1111;
        wlane_c = bus.WriteDataM;
        case (bus.Func3M[1:0])
            2'b00: begin
                be_c    = 4'b0001 << off_c;
                wlane_c = {4{bus.WriteDataM[7:0]}};
            end
            2'b01: begin
                be_c    = off_c[1] ? 4'b1100 : 4'b0011;
                wlane_c = {2{bus.WriteDataM[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wlane_c = bus.WriteDataM;
            end
        endcase
    end

    // Response cycle: same cycle as the request for zero latency, else RESP.
    always_comb begin
        resp_c = 1'b0;
        if (!reset && req_c) begin
            if (ZERO_LAT) resp_c = (state == IDLE);
            else          resp_c = (state == RESP);
        end
        we_c = resp_c & store_c & ~err_c;
    end

    // Load formatting from the source word.
    always_comb begin
        word_c      = ZERO_LAT ? mem[idx_c] : cap;
        byte_c      = word_c[8*off_c +: 8];
        half_c      = off_c[1] ? word_c[31:16] : word_c[15:0];
        load_data_c = '0;
        case (bus.Func3M)
            3'b000:  load_data_c = {{24{byte_c[7]}}, byte_c};
            3'b100:  load_data_c = {24'd0, byte_c};
            3'b001:  load_data_c = {{16{half_c[15]}}, half_c};
            3'b101:  load_data_c = {16'd0, half_c};
            3'b010:  load_data_c = word_c;
            default: load_data_c = '0;
        endcase
    end

    assign bus.ReadDataM = (resp_c && load_c && !err_c) ? load_data_c : 32'd0;
    assign bus.MemErrM   = resp_c & err_c;
    assign bus.MemStallM = ~reset & req_c
                         & ((state == WAIT) | ((state == IDLE) & !ZERO_LAT));

    // Array write; commits at the edge closing the response cycle.
    always_ff @(posedge clk) begin
        if (we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) mem[idx_c][8*i +: 8] <= wlane_c[8*i +: 8];
            end
        end
    end

    // Access sequencer; a dropped request in WAIT or RESP is a flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            cap   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_c && !ZERO_LAT) begin
                        if (ONE_LAT) begin
                            cap   <= mem[idx_c];
                            state <= RESP;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req_c) begin
                        cnt   <= 4'd0;
                        state <= IDLE;
                    end else if (cnt == 4'd1) begin
                        cap   <= mem[idx_c];
                        cnt   <= 4'd0;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
